mux_32_reg: RTL and testbench

- Registered 32-to-1 word multiplexer for the processor datapath.
- Selects one of 32 WIDTH-bit inputs using a 5-bit select and presents it on a registered output, one clock after sampling.
- Used wherever a register-file-style read or wide operand select needs a clean, flop-bounded timing path.

---
 rtl/mux_32_pkg.sv | 9 +
 rtl/mux_32_reg_if.sv | 45 ++++
 rtl/mux_32_reg_mux_2.sv | 15 +
 rtl/mux_32_reg.sv | 63 ++++++
 tb/tb_mux_32_reg.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/mux_32_pkg.sv
// mux_32_pkg: shared constants and select-index type for the 32-to-1 registered mux
//   MUX_32_SEL_W  : width of the select index
//   MUX_32_NUM_IN : number of data inputs
//   mux_32_sel_t  : unsigned select index type
package mux_32_pkg;
   localparam int MUX_32_SEL_W = 5;
   localparam int MUX_32_NUM_IN = 32;
   typedef logic [MUX_32_SEL_W-1:0] mux_32_sel_t;
endpackage

// File: rtl/mux_32_reg_if.sv
// mux_32_reg_if: bus bundle between a driver and the registered 32-to-1 mux
//   en          : capture enable
//   select      : input index 0..31
//   in0..in31   : WIDTH-bit data inputs
//   out         : registered selected data
//   out_parity  : registered even parity of the captured word (only with MUX_32_REG_PARITY_EN)
//   modports    : master drives en/select/inputs, slave (the mux) drives out
interface mux_32_reg_if
   import mux_32_pkg::*;
#(
   parameter int WIDTH = 32
);
   logic en;
   mux_32_sel_t select;
   logic [WIDTH-1:0] in0, in1, in2, in3, in4, in5, in6, in7;
   logic [WIDTH-1:0] in8, in9, in10, in11, in12, in13, in14, in15;
   logic [WIDTH-1:0] in16, in17, in18, in19, in20, in21, in22, in23;
   logic [WIDTH-1:0] in24, in25, in26, in27, in28, in29, in30, in31;
   logic [WIDTH-1:0] out;
`ifdef MUX_32_REG_PARITY_EN
   logic out_parity;
`endif
   modport master (
      output en, select,
      output in0, in1, in2, in3, in4, in5, in6, in7,
      output in8, in9, in10, in11, in12, in13, in14, in15,
      output in16, in17, in18, in19, in20, in21, in22, in23,
      output in24, in25, in26, in27, in28, in29, in30, in31,
      input out
`ifdef MUX_32_REG_PARITY_EN
      , input out_parity
`endif
   );
   modport slave (
      input en, select,
      input in0, in1, in2, in3, in4, in5, in6, in7,
      input in8, in9, in10, in11, in12, in13, in14, in15,
      input in16, in17, in18, in19, in20, in21, in22, in23,
      input in24, in25, in26, in27, in28, in29, in30, in31,
      output out
`ifdef MUX_32_REG_PARITY_EN
      , output out_parity
`endif
   );
endinterface

// File: rtl/mux_32_reg_mux_2.sv
// mux_2: WIDTH-bit combinational 2:1 mux, the leaf cell of the select tree
//   a : chosen when s == 0
//   b : chosen when s == 1
//   s : select bit
//   y : selected word
module mux_2 #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             s,
   output logic [WIDTH-1:0] y
);
   assign y = s ? b : a;
endmodule

// File: rtl/mux_32_reg.sv
// mux_32_reg: registered 32-to-1 word mux built from a balanced 5-level tree of 2:1 muxes
//   clock   : rising-edge clock
//   reset_n : synchronous active-low reset, clears out (and out_parity)
//   bus     : mux_32_reg_if.slave carrying en, select, in0..in31, out
//   Optional macro MUX_32_REG_PARITY_EN adds registered out_parity = ^in[select].
module mux_32_reg
   import mux_32_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input logic clock,
   input logic reset_n,
   mux_32_reg_if.slave bus
);
   logic [WIDTH-1:0] l0 [MUX_32_NUM_IN];
   logic [WIDTH-1:0] l1 [16];
   logic [WIDTH-1:0] l2 [8];
   logic [WIDTH-1:0] l3 [4];
   logic [WIDTH-1:0] l4 [2];
   logic [WIDTH-1:0] sel_data;
   logic [WIDTH-1:0] out_q;
   mux_32_sel_t sel;

   assign sel = bus.select;
   assign l0 = '{bus.in0, bus.in1, bus.in2, bus.in3, bus.in4, bus.in5, bus.in6, bus.in7,
                 bus.in8, bus.in9, bus.in10, bus.in11, bus.in12, bus.in13, bus.in14, bus.in15,
                 bus.in16, bus.in17, bus.in18, bus.in19, bus.in20, bus.in21, bus.in22, bus.in23,
                 bus.in24, bus.in25, bus.in26, bus.in27, bus.in28, bus.in29, bus.in30, bus.in31};

   // select[0] steers the leaf level, select[4] the root
   for (genvar i = 0; i < 16; i++) begin : g_l1
      mux_2 #(.WIDTH(WIDTH)) u_mux (.a(l0[2*i]), .b(l0[2*i+1]), .s(sel[0]), .y(l1[i]));
   end
   for (genvar i = 0; i < 8; i++) begin : g_l2
      mux_2 #(.WIDTH(WIDTH)) u_mux (.a(l1[2*i]), .b(l1[2*i+1]), .s(sel[1]), .y(l2[i]));
   end
   for (genvar i = 0; i < 4; i++) begin : g_l3
      mux_2 #(.WIDTH(WIDTH)) u_mux (.a(l2[2*i]), .b(l2[2*i+1]), .s(sel[2]), .y(l3[i]));
   end
   for (genvar i = 0; i < 2; i++) begin : g_l4
      mux_2 #(.WIDTH(WIDTH)) u_mux (.a(l3[2*i]), .b(l3[2*i+1]), .s(sel[3]), .y(l4[i]));
   end
   mux_2 #(.WIDTH(WIDTH)) u_root (.a(l4[0]), .b(l4[1]), .s(sel[4]), .y(sel_data));

   always_ff @(posedge clock) begin
      if (!reset_n)
         out_q <= '0;
      else if (bus.en)
         out_q <= sel_data;
   end
   assign bus.out = out_q;

`ifdef MUX_32_REG_PARITY_EN
   logic parity_q;
   always_ff @(posedge clock) begin
      if (!reset_n)
         parity_q <= 1'b0;
      else if (bus.en)
         parity_q <= ^sel_data;
   end
   assign bus.out_parity = parity_q;
`endif
endmodule

// File: tb/tb_mux_32_reg.sv
// tb_mux_32_reg: directed self-checking bench for mux_32_reg
module tb_mux_32_reg;
   import mux_32_pkg::*;
   logic clock = 1'b0;
   logic reset_n = 1'b0;
   logic [31:0] din [32];
   int passed = 0;
   int total = 0;

   mux_32_reg_if #(.WIDTH(32)) bus ();
   mux_32_reg #(.WIDTH(32)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));

   always #5 clock = ~clock;

   assign bus.in0 = din[0];   assign bus.in1 = din[1];   assign bus.in2 = din[2];   assign bus.in3 = din[3];
   assign bus.in4 = din[4];   assign bus.in5 = din[5];   assign bus.in6 = din[6];   assign bus.in7 = din[7];
   assign bus.in8 = din[8];   assign bus.in9 = din[9];   assign bus.in10 = din[10]; assign bus.in11 = din[11];
   assign bus.in12 = din[12]; assign bus.in13 = din[13]; assign bus.in14 = din[14]; assign bus.in15 = din[15];
   assign bus.in16 = din[16]; assign bus.in17 = din[17]; assign bus.in18 = din[18]; assign bus.in19 = din[19];
   assign bus.in20 = din[20]; assign bus.in21 = din[21]; assign bus.in22 = din[22]; assign bus.in23 = din[23];
   assign bus.in24 = din[24]; assign bus.in25 = din[25]; assign bus.in26 = din[26]; assign bus.in27 = din[27];
   assign bus.in28 = din[28]; assign bus.in29 = din[29]; assign bus.in30 = din[30]; assign bus.in31 = din[31];

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      bus.en = 1'b1;
      bus.select = 5'd9;
      for (int k = 0; k < 32; k++) din[k] = 32'hA5A5_0000 + k;
      tick();
      tick();
      total++;
      if (bus.out !== 32'h0) $display("FAIL reset_out: got %h want %h", bus.out, 32'h0);
      else passed++;
`ifdef MUX_32_REG_PARITY_EN
      total++;
      if (bus.out_parity !== 1'b0) $display("FAIL reset_parity: got %b want 0", bus.out_parity);
      else passed++;
`endif
      reset_n = 1'b1;
   endtask

   task automatic test_sweep();
      for (int k = 0; k < 32; k++) din[k] = k;
      bus.en = 1'b1;
      for (int s = 0; s < 32; s++) begin
         bus.select = mux_32_sel_t'(s);
         tick();
         total++;
         if (bus.out !== 32'(s)) $display("FAIL sweep_sel%0d: got %h want %h", s, bus.out, 32'(s));
         else passed++;
      end
   endtask

   task automatic test_reset_mid();
      bus.en = 1'b1;
      bus.select = 5'd12;
      tick();
      total++;
      if (bus.out !== 32'd12) $display("FAIL mid_load: got %h want %h", bus.out, 32'd12);
      else passed++;
      reset_n = 1'b0;
      tick();
      total++;
      if (bus.out !== 32'd0) $display("FAIL mid_reset: got %h want %h", bus.out, 32'd0);
      else passed++;
      reset_n = 1'b1;
      tick();
      total++;
      if (bus.out !== 32'd12) $display("FAIL mid_release: got %h want %h", bus.out, 32'd12);
      else passed++;
   endtask

   task automatic test_hold();
      bus.en = 1'b1;
      bus.select = 5'd5;
      tick();
      total++;
      if (bus.out !== 32'd5) $display("FAIL hold_load: got %h want %h", bus.out, 32'd5);
      else passed++;
      bus.en = 1'b0;
      bus.select = 5'd20;
      din[5] = 32'd99;
      for (int c = 0; c < 3; c++) begin
         tick();
         total++;
         if (bus.out !== 32'd5) $display("FAIL hold_edge%0d: got %h want %h", c, bus.out, 32'd5);
         else passed++;
      end
      bus.en = 1'b1;
      tick();
      total++;
      if (bus.out !== 32'd20) $display("FAIL hold_resume: got %h want %h", bus.out, 32'd20);
      else passed++;
      din[5] = 32'd5;
   endtask

   task automatic test_data_tracking();
      bus.en = 1'b1;
      bus.select = 5'd3;
      tick();
      total++;
      if (bus.out !== 32'd3) $display("FAIL track_init: got %h want %h", bus.out, 32'd3);
      else passed++;
      din[3] = 32'hDEAD_BEEF;
      tick();
      total++;
      if (bus.out !== 32'hDEAD_BEEF) $display("FAIL track_sel: got %h want %h", bus.out, 32'hDEAD_BEEF);
      else passed++;
      din[4] = 32'h1234;
      tick();
      total++;
      if (bus.out !== 32'hDEAD_BEEF) $display("FAIL track_unsel: got %h want %h", bus.out, 32'hDEAD_BEEF);
      else passed++;
   endtask

   task automatic test_wide();
      for (int k = 0; k < 32; k++) din[k] = 32'h0;
      din[0] = 32'hFFFF_FFFF;
      din[31] = 32'h8000_0001;
      bus.en = 1'b1;
      bus.select = 5'd0;
      tick();
      total++;
      if (bus.out !== 32'hFFFF_FFFF) $display("FAIL wide_sel0: got %h want %h", bus.out, 32'hFFFF_FFFF);
      else passed++;
      bus.select = 5'd31;
      tick();
      total++;
      if (bus.out !== 32'h8000_0001) $display("FAIL wide_sel31: got %h want %h", bus.out, 32'h8000_0001);
      else passed++;
      bus.select = 5'd30;
      tick();
      total++;
      if (bus.out !== 32'h0) $display("FAIL wide_sel30: got %h want %h", bus.out, 32'h0);
      else passed++;
   endtask

`ifdef MUX_32_REG_PARITY_EN
   task automatic test_parity();
      bus.en = 1'b1;
      bus.select = 5'd17;
      din[17] = 32'h7;
      tick();
      total++;
      if (bus.out_parity !== 1'b1) $display("FAIL parity_7: got %b want 1", bus.out_parity);
      else passed++;
      din[17] = 32'h3;
      tick();
      total++;
      if (bus.out_parity !== 1'b0) $display("FAIL parity_3: got %b want 0", bus.out_parity);
      else passed++;
      din[17] = 32'h8000_0000;
      tick();
      total++;
      if (bus.out_parity !== 1'b1) $display("FAIL parity_msb: got %b want 1", bus.out_parity);
      else passed++;
      reset_n = 1'b0;
      tick();
      total++;
      if (bus.out_parity !== 1'b0) $display("FAIL parity_reset: got %b want 0", bus.out_parity);
      else passed++;
      reset_n = 1'b1;
   endtask
`endif

   initial begin
      test_reset();
      test_sweep();
      test_reset_mid();
      test_hold();
      test_data_tracking();
      test_wide();
`ifdef MUX_32_REG_PARITY_EN
      test_parity();
`endif
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
